serial_subtractor: RTL and testbench

Bit-serial inverse of the 4-bit ripple-carry adder. It takes a 5-bit adder result {COUT,S}, the known operand B and the carry-in, and recovers the other operand A = {COUT,S} - B - CIN. The block processes one bit per clock through a single full-subtractor cell with a borrow flip-flop. It sits on the board datapath as the check stage for the adder: the recovered A must match the switch value. A start/busy/done handshake controls it, and it flags any result that no valid 4-bit A could produce.

---
 rtl/serial_subtractor_if.sv | 32 +++
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: handshake and data bundle for the bit-serial subtractor.
//   start : request, sampled only while the subtractor is idle
//   sum   : adder result {cout,s}, WIDTH+1 bits, captured on accept
//   b     : known adder operand, captured on accept
//   bin   : carry-in of the original add (initial borrow), captured on accept
//   diff  : recovered operand A
//   err   : result lies outside 0..2^WIDTH-1
//   busy  : operation in progress
//   done  : one-cycle pulse when diff/err update
// master drives the request side, slave is the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output start, sum, b, bin,
        input  diff, err, busy, done
    );

    modport slave (
        input  start, sum, b, bin,
        output diff, err, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial inverse of a WIDTH-bit ripple-carry adder.
// Recovers A = sum - b - bin one bit per clock through a single full-subtractor
// cell and a borrow flip-flop, taking WIDTH+1 shift cycles per operation.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   bus   : serial_subtractor_if slave (start/sum/b/bin in, diff/err/busy/done out)
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_shift = 2'd1,
        st_done  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   m_q;      // minuend shift register
    logic [WIDTH:0]   s_q;      // subtrahend shift register
    logic [WIDTH-1:0] r_q;      // partial result, upper bits of the final word
    logic             bw_q;     // borrow flip-flop
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             err_q;
    logic             busy_q;
    logic             done_q;

    logic             d;
    logic             bw_n;
    logic [WIDTH:0]   r_n;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d    = m_q[0] ^ s_q[0] ^ bw_q;
        bw_n = (~m_q[0] & s_q[0]) | (~m_q[0] & bw_q) | (s_q[0] & bw_q);
        // New bit enters at the MSB; on the last cycle r_n is the full result.
        r_n  = {d, r_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= st_idle;
            m_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q     <= bus.sum;
                        s_q     <= {1'b0, bus.b};
                        bw_q    <= bus.bin;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= st_shift;
                    end
                end
                st_shift: begin
                    m_q   <= m_q >> 1;
                    s_q   <= s_q >> 1;
                    r_q   <= r_n[WIDTH:1];
                    bw_q  <= bw_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH)) begin
                        // Final borrow: negative; set MSB: above 2^WIDTH-1.
                        diff_q  <= r_n[WIDTH-1:0];
                        err_q   <= bw_n | r_n[WIDTH];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= st_done;
                    end
                end
                st_done: begin
                    done_q  <= 1'b0;
                    state_q <= st_idle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= st_idle;
                end
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// against an arithmetic reference (A = sum - b - bin, err when out of range).
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [W-1:0] prev_diff;
    logic         prev_err;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an operation from the current negedge and follows it through done.
    // wait_cycles: negedges expected before busy shows (0 from idle, 1 when
    // start is raised during the done cycle of the previous operation).
    // hold: keep start high through the whole operation.
    task automatic run(input logic [W:0] sm, input logic [W-1:0] bb, input logic bi,
                       input int wait_cycles, input bit hold, input string tag);
        int n;
        int r;
        logic [W-1:0] exp_diff;
        logic         exp_err;
        r        = int'(sm) - int'(bb) - int'(bi);
        exp_diff = W'(r & ((1 << W) - 1));
        exp_err  = (r < 0) || (r > (1 << W) - 1);

        bus.sum   = sm;
        bus.b     = bb;
        bus.bin   = bi;
        bus.start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.busy && n < 4) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " accept_latency"}, 32'(n), 32'(wait_cycles));
        if (!hold) bus.start = 1'b0;
        // Captured operands must not be affected by later input changes.
        bus.sum = (W+1)'($urandom);
        bus.b   = W'($urandom);
        bus.bin = 1'($urandom);
        for (int i = 0; i <= int'(W); i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, " busy"}, 32'(bus.busy), 32'(1));
            chk({tag, " no_done"}, 32'(bus.done), 32'(0));
            chk({tag, " diff_hold"}, 32'(bus.diff), 32'(prev_diff));
            chk({tag, " err_hold"}, 32'(bus.err), 32'(prev_err));
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " done"}, 32'(bus.done), 32'(1));
        chk({tag, " busy_low"}, 32'(bus.busy), 32'(0));
        chk({tag, " diff"}, 32'(bus.diff), 32'(exp_diff));
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        prev_diff = exp_diff;
        prev_err  = exp_err;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_diff = '0;
        prev_err  = 1'b0;
        bus.start = 1'b1;
        bus.sum   = 5'd7;
        bus.b     = 4'd1;
        bus.bin   = 1'b0;
        reset     = 1'b1;

        // Reset wins over start.
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'(0));
        chk("rst done", 32'(bus.done), 32'(0));
        chk("rst diff", 32'(bus.diff), 32'(0));
        chk("rst err", 32'(bus.err), 32'(0));
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(bus.busy), 32'(0));

        // Directed cases.
        run(5'b10011, 4'd6, 1'b0, 0, 1'b0, "dir19");
        @(negedge clk);
        chk("dir19 single_done", 32'(bus.done), 32'(0));
        run(5'd16, 4'd1, 1'b0, 0, 1'b0, "dir16");
        run(5'd0, 4'd0, 1'b1, 1, 1'b0, "neg");
        run(5'd31, 4'd0, 1'b0, 1, 1'b0, "over");
        run(5'd20, 4'd15, 1'b1, 1, 1'b0, "dir20");

        // Every valid A, B, CIN round-trips; back-to-back cadence checked.
        for (int a = 0; a < 16; a++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    run(5'(a + bv + c), 4'(bv), 1'(c), 1, 1'b0, "exh");
                    chk("exh roundtrip", 32'(bus.diff), 32'(a));
                end
            end
        end
        @(negedge clk);

        // Random operands, including invalid results.
        for (int k = 0; k < 40; k++) begin
            run(5'($urandom), 4'($urandom), 1'($urandom), (k == 0) ? 0 : 1, 1'b0, "rnd");
        end
        @(negedge clk);

        // Start held high throughout: exactly one operation and one done.
        run(5'd25, 4'd9, 1'b1, 0, 1'b1, "hold");
        @(negedge clk);
        chk("hold single_done", 32'(bus.done), 32'(0));
        @(negedge clk);
        chk("hold no_restart", 32'(bus.busy), 32'(0));

        // Reset on the third shift cycle aborts with no done.
        bus.sum   = 5'd18;
        bus.b     = 4'd3;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy_low", 32'(bus.busy), 32'(0));
        chk("abort no_done", 32'(bus.done), 32'(0));
        chk("abort diff", 32'(bus.diff), 32'(0));
        chk("abort err", 32'(bus.err), 32'(0));
        prev_diff = '0;
        prev_err  = 1'b0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(negedge clk);
            chk("abort quiet", 32'(bus.done), 32'(0));
        end
        run(5'd18, 4'd3, 1'b0, 0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
